seg_scan_bcd: RTL and testbench
===============================

Name: seg_scan_bcd

Overview:
Parametrised successor to the single-byte seven-segment driver. It converts a BIN_W-bit binary value to DIGITS packed BCD digits using a sequential double-dabble converter, started by a load/busy/done handshake. It then time-multiplexes the result onto a common-anode (or common-cathode) multi-digit display. Adds leading-zero blanking, per-digit decimal points, overflow indication and a programmable scan rate.

Parameters:
BIN_W, 8, width of binary input; legal 1..32
DIGITS, 4, number of display digits / BCD nibbles; legal 1..8
SCAN_DIV, 50000, clocks each digit stays lit; legal >=1
ACTIVE_LOW, 1, 1: DIG and Y active-low; 0: both active-high

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-low reset
num  input  BIN_W  binary value, sampled on accepted load
load  input  1  start-conversion strobe
blank_lz  input  1  1 = blank leading zero digits
dp_mask  input  DIGITS  bit i lights the decimal point of digit i
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when bcd/ovf are updated
bcd  output  4*DIGITS  last completed result; nibble 0 = units
ovf  output  1  last result exceeded 10^DIGITS-1
DIG  output  DIGITS  digit enables, one-hot (polarity per ACTIVE_LOW)
Y  output  8  segments {dp,g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)

Behaviour:
- Reset (rst==0 at posedge) has priority over everything.
  - Effect: converter FSM -> IDLE; busy=0, done=0, bcd=0, ovf=0; scan index=0, prescaler=0.
  - Outputs (ACTIVE_LOW=1, DIGITS=4): DIG=4'b1110, Y=8'b1100_0000 ('0').
- Reset mid-conversion aborts the conversion: no done pulse, and bcd returns to 0.
- Converter FSM states:
  - IDLE: load=1 captures num into the shift register, clears scratch BCD and the ovf scratch -> SHIFT; busy=1 from the next edge.
  - SHIFT: runs exactly BIN_W cycles. Each cycle, every BCD nibble >=5 gets +3, then the whole {BCD,bin} register shifts left 1. A 1 shifted out of the top nibble sets the sticky ovf scratch. After BIN_W cycles -> DONE.
  - DONE: bcd<=scratch, ovf<=ovf scratch, done=1 for this single cycle, busy=0 -> IDLE.
- Latency: load accepted at edge t -> done high and bcd valid after edge t+BIN_W+1. A new load is accepted the cycle after done.
- Loads while busy are ignored, not queued. num changes while busy have no effect.
- Display always shows the last completed bcd/ovf; it does not change during conversion.
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, the scan index advances 0..DIGITS-1 and wraps to 0.
  - SCAN_DIV=1 advances every cycle.
- DIG and Y are registered from the same scan index on the same edge. The enabled digit and its segment pattern are always consistent, with one cycle of latency from the index.
- Segment codes (active-low form; invert all 8 bits when ACTIVE_LOW=0):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Blank=FF. Dash '-'=BF.
- Digit i is blanked when all of the following hold: blank_lz=1, i>0, and nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked.
- ovf=1 overrides the digit contents: every digit shows a dash.
- dp: when dp_mask[i]=1, bit 7 of Y is forced active while digit i is lit. This applies to blanked and dash digits too.
- dp_mask and blank_lz are sampled combinationally when Y is registered; no synchronisation is required.

Test Plan:
1. Reset hold -> rst=0 for 2 cycles -> DIG=4'b1110, Y=8'hC0, bcd=0, busy=0, done=0, ovf=0.
2. Conversion and scan (SCAN_DIV=1) -> num=8'd255, load pulse -> busy for 8 cycles, done at t+9, bcd=16'h0255, ovf=0. Scan then gives DIG 1110/1101/1011/0111 with Y 92/92/A4/C0 repeating.
3. Leading-zero blanking -> blank_lz=1, num=7 -> digit0 Y=F8, digits 1..3 Y=FF. With num=0, digit0 Y=C0 and the rest FF.
4. Overflow boundary (BIN_W=16, DIGITS=4):
   - num=9999 -> bcd=16'h9999, ovf=0.
   - num=10000 -> ovf=1, all digits Y=BF.
   - num=65535 -> ovf=1.
5. Handshake and reset:
   - load asserted again during busy -> ignored; exactly one done; result belongs to the first num.
   - rst=0 on the 4th SHIFT cycle -> busy=0, bcd=0, no done pulse.
6. Decimal point and polarity:
   - dp_mask=4'b0010, num=0, blank_lz=0 -> digit1 Y=8'h40, others C0.
   - Rerun with ACTIVE_LOW=0 -> DIG one-hot high, digit1 Y=8'hBF.

Source files
------------

// File: rtl/seg_scan_bcd_if.sv
// Handshake and display bundle for seg_scan_bcd: the master drives the conversion
// and display controls, the slave returns status, the BCD result and the scan outputs.
interface seg_scan_bcd_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 4
);
   logic [BIN_W-1:0]    num;
   logic                load;
   logic                blank_lz;
   logic [DIGITS-1:0]   dp_mask;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] bcd;
   logic                ovf;
   logic [DIGITS-1:0]   DIG;
   logic [7:0]          Y;

   modport master (
      output num, load, blank_lz, dp_mask,
      input  busy, done, bcd, ovf, DIG, Y
   );

   modport slave (
      input  num, load, blank_lz, dp_mask,
      output busy, done, bcd, ovf, DIG, Y
   );
endinterface

// File: rtl/seg_scan_bcd.sv
// Sequential double-dabble binary-to-BCD converter feeding a time-multiplexed
// seven-segment scanner with leading-zero blanking, decimal points and overflow dashes.
module seg_scan_bcd #(
   parameter int BIN_W      = 8,
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic          clk,
   input  logic          rst,
   seg_scan_bcd_if.slave bus
);

   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BCD_W = 4 * DIGITS;
   localparam logic [7:0]        Y_POL = (ACTIVE_LOW != 0) ? 8'h00 : 8'hFF;
   localparam logic [DIGITS-1:0] D_POL = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_reg;
   logic [BIN_W-1:0]  bin_reg;
   logic [BCD_W-1:0]  scratch_reg;
   logic              ovf_scratch_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [BCD_W-1:0]  bcd_reg;
   logic              ovf_reg;

   logic [PRE_W-1:0]  pre_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [DIGITS-1:0] dig_reg;
   logic [7:0]        y_reg;

   logic [BCD_W-1:0]  adj;
   logic [7:0]        code [DIGITS];
   logic [DIGITS-1:0] sel;

   function automatic logic [7:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 8'hC0;
         4'd1:    seg_code = 8'hF9;
         4'd2:    seg_code = 8'hA4;
         4'd3:    seg_code = 8'hB0;
         4'd4:    seg_code = 8'h99;
         4'd5:    seg_code = 8'h92;
         4'd6:    seg_code = 8'h82;
         4'd7:    seg_code = 8'hF8;
         4'd8:    seg_code = 8'h80;
         4'd9:    seg_code = 8'h90;
         default: seg_code = 8'hFF;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] nib;
         logic [3:0] scr;
         logic       blank;
         logic [7:0] base;

         assign scr = scratch_reg[4*gi +: 4];
         assign adj[4*gi +: 4] = (scr >= 4'd5) ? scr + 4'd3 : scr;
         assign nib = bcd_reg[4*gi +: 4];

         // A digit is a leading zero when it and everything above it is zero.
         if (gi == 0) begin : g_first
            assign blank = 1'b0;
         end else begin : g_rest
            assign blank = bus.blank_lz && (bcd_reg[BCD_W-1:4*gi] == '0);
         end

         assign base     = ovf_reg ? 8'hBF : (blank ? 8'hFF : seg_code(nib));
         assign code[gi] = {base[7] & ~bus.dp_mask[gi], base[6:0]};
         assign sel[gi]  = (idx_reg == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg       <= IDLE;
         bin_reg         <= '0;
         scratch_reg     <= '0;
         ovf_scratch_reg <= 1'b0;
         cnt_reg         <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         bcd_reg         <= '0;
         ovf_reg         <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.load) begin
                  bin_reg         <= bus.num;
                  scratch_reg     <= '0;
                  ovf_scratch_reg <= 1'b0;
                  cnt_reg         <= '0;
                  state_reg       <= SHIFT;
               end
            end
            SHIFT: begin
               busy_reg <= 1'b1;
               // Adjust then shift; a carry out of the top nibble means the value needs another digit.
               {scratch_reg, bin_reg} <= {adj[BCD_W-2:0], bin_reg, 1'b0};
               ovf_scratch_reg        <= ovf_scratch_reg | adj[BCD_W-1];
               cnt_reg                <= cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_W'(BIN_W - 1))
                  state_reg <= DONE;
            end
            DONE: begin
               bcd_reg   <= scratch_reg;
               ovf_reg   <= ovf_scratch_reg;
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pre_reg <= '0;
         idx_reg <= '0;
         dig_reg <= DIGITS'(1) ^ D_POL;
         y_reg   <= 8'hC0 ^ Y_POL;
      end else begin
         // Enable and pattern come from the same index so they never disagree.
         dig_reg <= sel ^ D_POL;
         y_reg   <= code[idx_reg] ^ Y_POL;
         if (pre_reg == PRE_W'(SCAN_DIV - 1)) begin
            pre_reg <= '0;
            idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
         end else begin
            pre_reg <= pre_reg + PRE_W'(1);
         end
      end
   end

   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
   assign bus.bcd  = bcd_reg;
   assign bus.ovf  = ovf_reg;
   assign bus.DIG  = dig_reg;
   assign bus.Y    = y_reg;

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Directed bench for seg_scan_bcd: three instances cover 8-bit and 16-bit inputs,
// both display polarities and two scan rates.
module tb_seg_scan_bcd;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   seg_scan_bcd_if #(.BIN_W(8),  .DIGITS(4)) ia ();
   seg_scan_bcd_if #(.BIN_W(16), .DIGITS(4)) ib ();
   seg_scan_bcd_if #(.BIN_W(8),  .DIGITS(4)) ic ();

   seg_scan_bcd #(.BIN_W(8),  .DIGITS(4), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   seg_scan_bcd #(.BIN_W(16), .DIGITS(4), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
   seg_scan_bcd #(.BIN_W(8),  .DIGITS(4), .SCAN_DIV(3), .ACTIVE_LOW(0)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      int          w;
      logic [31:0] num;
      logic        blz;
      logic [3:0]  dp;
      logic        chk_bcd;
      logic [15:0] bcd;
      logic        ovf;
      logic [31:0] y;      // digit3..digit0 segment bytes as they appear on Y
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic set_in(input int w, input logic [31:0] n, input logic ld);
      case (w)
         0:       begin ia.num = n[7:0];  ia.load = ld; end
         1:       begin ib.num = n[15:0]; ib.load = ld; end
         default: begin ic.num = n[7:0];  ic.load = ld; end
      endcase
   endtask

   task automatic set_disp(input int w, input logic blz, input logic [3:0] dp);
      case (w)
         0:       begin ia.blank_lz = blz; ia.dp_mask = dp; end
         1:       begin ib.blank_lz = blz; ib.dp_mask = dp; end
         default: begin ic.blank_lz = blz; ic.dp_mask = dp; end
      endcase
   endtask

   function automatic logic get_done(input int w);
      case (w) 0: return ia.done; 1: return ib.done; default: return ic.done; endcase
   endfunction
   function automatic logic get_busy(input int w);
      case (w) 0: return ia.busy; 1: return ib.busy; default: return ic.busy; endcase
   endfunction
   function automatic logic get_ovf(input int w);
      case (w) 0: return ia.ovf; 1: return ib.ovf; default: return ic.ovf; endcase
   endfunction
   function automatic logic [15:0] get_bcd(input int w);
      case (w) 0: return ia.bcd; 1: return ib.bcd; default: return ic.bcd; endcase
   endfunction
   function automatic logic [3:0] get_dig(input int w);
      case (w) 0: return ia.DIG; 1: return ib.DIG; default: return ic.DIG; endcase
   endfunction
   function automatic logic [7:0] get_y(input int w);
      case (w) 0: return ia.Y; 1: return ib.Y; default: return ic.Y; endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse load for one edge, then count edges until done (bounded).
   task automatic conv(input int w, input logic [31:0] n, output int lat, output int busy_cycles);
      @(negedge clk);
      set_in(w, n, 1'b1);
      tick();
      set_in(w, n, 1'b0);
      lat = 0;
      busy_cycles = 0;
      while (lat < 60 && !get_done(w)) begin
         if (get_busy(w)) busy_cycles++;
         tick();
         lat++;
      end
   endtask

   // Visit every digit (bounded wait for its enable) and compare its segment byte.
   task automatic scan_check(input int w, input logic [31:0] exp_y, input string name);
      logic [3:0] target;
      int t;
      for (int d = 0; d < 4; d++) begin
         target = (4'b0001 << d) ^ ((w == 2) ? 4'h0 : 4'hF);
         t = 0;
         while (t < 30 && get_dig(w) !== target) begin
            tick();
            t++;
         end
         check($sformatf("%s_dig%0d", name, d), {28'd0, get_dig(w)}, {28'd0, target});
         check($sformatf("%s_y%0d", name, d), {24'd0, get_y(w)}, {24'd0, exp_y[8*d +: 8]});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bc, t, n, dones;
      logic [3:0] prev;
      logic [7:0] rot_y [4];
      logic [3:0] exp_dig;

      vecs[0]  = '{0, 32'd255,   1'b0, 4'b0000, 1'b1, 16'h0255, 1'b0, 32'hC0A49292};
      vecs[1]  = '{0, 32'd7,     1'b1, 4'b0000, 1'b1, 16'h0007, 1'b0, 32'hFFFFFFF8};
      vecs[2]  = '{0, 32'd0,     1'b1, 4'b0000, 1'b1, 16'h0000, 1'b0, 32'hFFFFFFC0};
      vecs[3]  = '{1, 32'd9999,  1'b0, 4'b0000, 1'b1, 16'h9999, 1'b0, 32'h90909090};
      vecs[4]  = '{1, 32'd10000, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b1, 32'hBFBFBFBF};
      vecs[5]  = '{1, 32'd65535, 1'b1, 4'b0000, 1'b0, 16'h0000, 1'b1, 32'hBFBFBFBF};
      vecs[6]  = '{1, 32'd10000, 1'b0, 4'b0100, 1'b0, 16'h0000, 1'b1, 32'hBF3FBFBF};
      vecs[7]  = '{0, 32'd0,     1'b0, 4'b0010, 1'b1, 16'h0000, 1'b0, 32'hC0C040C0};
      vecs[8]  = '{2, 32'd0,     1'b0, 4'b0010, 1'b1, 16'h0000, 1'b0, 32'h3F3FBF3F};
      vecs[9]  = '{2, 32'd37,    1'b1, 4'b0000, 1'b1, 16'h0037, 1'b0, 32'h00004F07};
      vecs[10] = '{0, 32'd100,   1'b1, 4'b1000, 1'b1, 16'h0100, 1'b0, 32'h7FF9C0C0};

      for (int w = 0; w < 3; w++) begin
         set_in(w, 32'd0, 1'b0);
         set_disp(w, 1'b0, 4'b0000);
      end

      // Reset hold
      rst = 1'b0;
      repeat (2) tick();
      check("rst_dig_a",  {28'd0, ia.DIG}, 32'h0000000E);
      check("rst_y_a",    {24'd0, ia.Y},   32'h000000C0);
      check("rst_bcd_a",  {16'd0, ia.bcd}, 32'h00000000);
      check("rst_busy_a", {31'd0, ia.busy}, 32'd0);
      check("rst_done_a", {31'd0, ia.done}, 32'd0);
      check("rst_ovf_a",  {31'd0, ia.ovf},  32'd0);
      check("rst_dig_c",  {28'd0, ic.DIG}, 32'h00000001);
      check("rst_y_c",    {24'd0, ic.Y},   32'h0000003F);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 11; i++) begin
         set_disp(vecs[i].w, vecs[i].blz, vecs[i].dp);
         conv(vecs[i].w, vecs[i].num, lat, bc);
         $display("vec %0d: inst=%0d num=%0d lat=%0d busy=%0d bcd=%h ovf=%b",
                  i, vecs[i].w, vecs[i].num, lat, bc, get_bcd(vecs[i].w), get_ovf(vecs[i].w));
         check($sformatf("v%0d_lat", i), lat, (vecs[i].w == 1) ? 32'd17 : 32'd9);
         check($sformatf("v%0d_busy", i), bc, (vecs[i].w == 1) ? 32'd16 : 32'd8);
         check($sformatf("v%0d_busy_at_done", i), {31'd0, get_busy(vecs[i].w)}, 32'd0);
         check($sformatf("v%0d_ovf", i), {31'd0, get_ovf(vecs[i].w)}, {31'd0, vecs[i].ovf});
         if (vecs[i].chk_bcd)
            check($sformatf("v%0d_bcd", i), {16'd0, get_bcd(vecs[i].w)}, {16'd0, vecs[i].bcd});
         tick();
         check($sformatf("v%0d_done_clear", i), {31'd0, get_done(vecs[i].w)}, 32'd0);
         scan_check(vecs[i].w, vecs[i].y, $sformatf("v%0d", i));
      end

      // Scan rotation at SCAN_DIV=1 after converting 255
      set_disp(0, 1'b0, 4'b0000);
      conv(0, 32'd255, lat, bc);
      rot_y[0] = 8'h92; rot_y[1] = 8'h92; rot_y[2] = 8'hA4; rot_y[3] = 8'hC0;
      t = 0;
      while (t < 20 && ia.DIG !== 4'b1110) begin tick(); t++; end
      check("rot_start", {28'd0, ia.DIG}, 32'h0000000E);
      for (int k = 1; k < 8; k++) begin
         tick();
         exp_dig = ~(4'b0001 << (k % 4));
         check($sformatf("rot%0d_dig", k), {28'd0, ia.DIG}, {28'd0, exp_dig});
         check($sformatf("rot%0d_y", k), {24'd0, ia.Y}, {24'd0, rot_y[k % 4]});
      end
      $display("scan rotation checked on instance 0");

      // Prescaler period on the SCAN_DIV=3 instance
      for (int r = 0; r < 2; r++) begin
         prev = ic.DIG;
         t = 0;
         while (t < 20 && ic.DIG === prev) begin tick(); t++; end
         prev = ic.DIG;
         n = 0;
         while (n < 20 && ic.DIG === prev) begin tick(); n++; end
         check($sformatf("scan_period%0d", r), n, 32'd3);
      end
      $display("scan period checked on instance 2");

      // Loads during busy are ignored
      @(negedge clk);
      ia.num = 8'd18; ia.load = 1'b1;
      tick();
      ia.num = 8'd99;
      repeat (3) tick();
      ia.load = 1'b0;
      dones = 0;
      for (int c = 0; c < 30; c++) begin
         if (ia.done) dones++;
         tick();
      end
      check("busy_load_dones", dones, 32'd1);
      check("busy_load_bcd", {16'd0, ia.bcd}, 32'h00000018);
      $display("load-while-busy: dones=%0d bcd=%h", dones, ia.bcd);

      // Reset on the 4th SHIFT cycle aborts the conversion
      @(negedge clk);
      ia.num = 8'd200; ia.load = 1'b1;
      tick();
      ia.load = 1'b0;
      repeat (3) tick();
      check("abort_busy_before", {31'd0, ia.busy}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("abort_busy", {31'd0, ia.busy}, 32'd0);
      check("abort_bcd",  {16'd0, ia.bcd},  32'h00000000);
      check("abort_done", {31'd0, ia.done}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (ia.done) dones++;
      end
      check("abort_no_done", dones, 32'd0);
      $display("reset-abort: dones=%0d bcd=%h", dones, ia.bcd);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
